// File: rtl/systolic_ctrl.sv
// Sequencer for the 2x2 systolic array: latches operands, clears the array, feeds the skewed stream, returns C.
// Optional build macro SYS_CTRL_TIMEOUT_EN bounds the WAIT state and flags err on expiry.
module systolic_ctrl #(
   parameter int DW          = 8,
   parameter int CW          = 15,
   parameter int CLR_CYC     = 1,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            ready,
   input  logic [4*DW-1:0] a_mat,
   input  logic [4*DW-1:0] b_mat,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4*CW-1:0] c_mat,
   output logic            busy,
   output logic            err,
   output logic            arr_rst,
   output logic [DW-1:0]   arr_a1,
   output logic [DW-1:0]   arr_a2,
   output logic [DW-1:0]   arr_b1,
   output logic [DW-1:0]   arr_b2,
   input  logic [CW-1:0]   arr_c11,
   input  logic [CW-1:0]   arr_c12,
   input  logic [CW-1:0]   arr_c21,
   input  logic [CW-1:0]   arr_c22,
   input  logic            arr_done
);

   // One counter serves both the CLR hold and the WAIT timeout, so size it for the larger.
   localparam int CLR_W = $clog2(CLR_CYC + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int CNTW  = (CLR_W > TO_W) ? CLR_W : TO_W;
   localparam logic [CNTW-1:0] CLR_LAST = CNTW'(CLR_CYC - 1);
`ifdef SYS_CTRL_TIMEOUT_EN
   localparam logic [CNTW-1:0] TO_LAST  = CNTW'(TIMEOUT_CYC - 1);
`endif

   typedef enum logic [2:0] {
      IDLE, CLR, F0, F1, F2, F3, WAIT, RESP
   } state_t;

   state_t          state;
   logic [4*DW-1:0] a_q;
   logic [4*DW-1:0] b_q;
   logic [CNTW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         cnt       <= '0;
         ready     <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         c_mat     <= '0;
         arr_rst   <= 1'b0;
         arr_a1    <= '0;
         arr_a2    <= '0;
         arr_b1    <= '0;
         arr_b2    <= '0;
      end else begin
         case (state)
            IDLE: begin
               arr_rst <= 1'b1;
               if (start && ready) begin
                  a_q     <= a_mat;
                  b_q     <= b_mat;
                  cnt     <= '0;
                  arr_rst <= 1'b0;
                  ready   <= 1'b0;
                  busy    <= 1'b1;
                  err     <= 1'b0;
                  state   <= CLR;
               end
            end
            CLR: begin
               if (cnt == CLR_LAST) begin
                  arr_rst <= 1'b1;
                  arr_a1  <= a_q[0*DW +: DW];
                  arr_b1  <= b_q[0*DW +: DW];
                  arr_a2  <= '0;
                  arr_b2  <= '0;
                  state   <= F0;
               end else begin
                  cnt <= cnt + CNTW'(1);
               end
            end
            F0: begin
               arr_a1 <= a_q[1*DW +: DW];
               arr_b1 <= b_q[2*DW +: DW];
               arr_a2 <= a_q[2*DW +: DW];
               arr_b2 <= b_q[1*DW +: DW];
               state  <= F1;
            end
            F1: begin
               arr_a1 <= '0;
               arr_b1 <= '0;
               arr_a2 <= a_q[3*DW +: DW];
               arr_b2 <= b_q[3*DW +: DW];
               state  <= F2;
            end
            F2: begin
               arr_a1 <= '0;
               arr_b1 <= '0;
               arr_a2 <= '0;
               arr_b2 <= '0;
               state  <= F3;
            end
            F3: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (arr_done) begin
                  c_mat     <= {arr_c22, arr_c21, arr_c12, arr_c11};
                  out_valid <= 1'b1;
                  state     <= RESP;
`ifdef SYS_CTRL_TIMEOUT_EN
               end else if (cnt == TO_LAST) begin
                  err       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + CNTW'(1);
`endif
               end
            end
            RESP: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  ready     <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for the 2x2 systolic matrix-multiply array (systolic_2x2). It accepts two packed 2x2 operand matrices through a valid/ready request port and clears the array. It then drives the skewed operand stream on a1/a2/b1/b2, waits for the array's done, and returns the four products on a valid/ready response port.

Parameters:
DW, 8, operand element width (array a/b port width)
CW, 15, result element width (array c port width)
CLR_CYC, 1, cycles arr_rst is held low before feeding (>=1)
TIMEOUT_CYC, 16, max WAIT cycles before error (used only with SYS_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  request valid
ready  out  1  request ready; high only in IDLE
a_mat  in  4*DW  A packed: [DW-1:0]=A00, next=A01, next=A10, top=A11
b_mat  in  4*DW  B packed, same order
out_valid  out  1  result valid
out_ready  in  1  result accepted
c_mat  out  4*CW  C packed: C00,C01,C10,C11 from LSB
busy  out  1  high in every state except IDLE
err  out  1  timeout flag (0 when feature is off)
arr_rst  out  1  array reset, active-low
arr_a1, arr_a2, arr_b1, arr_b2  out  DW each  array operand inputs
arr_c11, arr_c12, arr_c21, arr_c22  in  CW each  array results
arr_done  in  1  array completion

Behaviour:
- Reset (rst=0, async): state=IDLE, ready=1, busy=0, out_valid=0, err=0, c_mat=0, arr_rst=0, all arr_a*/arr_b*=0. Operand latches are cleared.
- All outputs are registered. arr_rst=1 in every state except CLR and reset.
- IDLE: if start&&ready, latch a_mat/b_mat and go to CLR. Otherwise stay.
- CLR: arr_rst=0 for CLR_CYC cycles (counter), then go to F0.
- F0: a1=A00, b1=B00, a2=0, b2=0.
- F1: a1=A01, b1=B10, a2=A10, b2=B01.
- F2: a1=0, b1=0, a2=A11, b2=B11.
- F3: all operands 0 (flush). Then go to WAIT.
- Each F state lasts exactly 1 cycle. The operand values appear on the arr_* registers during the cycle the FSM is in that state.
- WAIT: operands held at 0. When arr_done=1, capture arr_c11/c12/c21/c22 into c_mat (C00/C01/C10/C11), set out_valid=1 and go to RESP.
- arr_done sampled in CLR or F0..F3 is ignored.
- RESP: hold c_mat and out_valid until out_ready=1. On that edge, clear out_valid and return to IDLE; ready=1 next cycle. c_mat holds its last value.
- Minimum start-to-out_valid latency: 1+CLR_CYC+4+1 cycles (arr_done high on WAIT entry).
- start while busy: ignored, not queued; latched operands are unchanged.
- out_ready outside RESP: ignored.
- Arithmetic: results are pass-through, no saturation. Overflow beyond CW is the array's wrap behaviour.
- Reset mid-operation: returns immediately to the reset values above and discards any pending result.

Optional Feature:
SYS_CTRL_TIMEOUT_EN
- Defined: WAIT counts cycles. If arr_done has not arrived after TIMEOUT_CYC cycles, set err=1, leave c_mat at its previous value, and go to RESP with out_valid=1. err clears on the next accepted start.
- Not defined: WAIT waits indefinitely, err is tied 0, and TIMEOUT_CYC is unused.

Test Plan:
1. Basic multiply. a_mat=0x04030201, b_mat=0x08070605 with an array model; hold out_ready=1. Required: operand sequence (a1,a2,b1,b2) is (1,0,5,0), (2,3,7,6), (0,4,0,8), (0,0,0,0). Then c_mat = C00=19, C01=22, C10=43, C11=50, with out_valid for exactly 1 cycle.
2. Response stall. out_ready=0 for 5 cycles after out_valid. Required: out_valid and c_mat stable, ready=0 throughout. Transaction completes on the cycle out_ready=1.
3. Start while busy. Pulse start with a_mat=0xFFFFFFFF during F1. Required: ignored, and the result still equals test 1.
4. Back-to-back. Second request (A=identity 0x01000001, B=0x08070605) issued the cycle ready returns. Required: arr_rst low again for CLR_CYC cycles, then c_mat = 5,6,7,8.
5. Reset mid-operation. rst=0 during F2. Required: all outputs at reset values asynchronously, and no out_valid after rst is released.
6. Timeout (with SYS_CTRL_TIMEOUT_EN). arr_done held 0. Required: err=1 and out_valid=1 after TIMEOUT_CYC=16 WAIT cycles. Next start clears err. Without the macro, the controller stays in WAIT with err=0.
